// File: rtl/seg_display_scan.sv
// Multi-digit seven-segment display driver: accepts a binary value through a
// valid/ready handshake, converts it to BCD with a serial double-dabble engine,
// and time-multiplexes the stored digits onto a shared segment bus with
// one-hot digit enables, leading-zero blanking and overflow dashes.
module seg_display_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned IN_WIDTH   = 14,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [IN_WIDTH-1:0]   num,
  input  logic                  blank_lz,
  output logic                  ready_out,
  output logic                  done,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Nibbles needed for 2^IN_WIDTH-1 (0.302 slightly over-estimates log10(2)),
  // never fewer than the number of displayed digits.
  localparam int unsigned BCD_MIN = (IN_WIDTH * 302) / 1000 + 1;
  localparam int unsigned NB      = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int unsigned BW      = NB * 4;
  localparam int unsigned DW      = NUM_DIGITS * 4;
  localparam int unsigned CW      = $clog2(IN_WIDTH + 1);
  localparam int unsigned PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [31:0]           LIMIT    = 32'(pow10(NUM_DIGITS));
  localparam logic [6:0]            SEG_DASH = 7'b1000000;
  localparam logic [6:0]            SEG_ZERO = 7'b0111111;
  localparam logic [6:0]            SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_RST   = NUM_DIGITS'(1) ^ AN_POL;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                state;
  logic [IN_WIDTH-1:0]   bin_q;
  logic [BW-1:0]         bcd_q;
  logic [BW-1:0]         adj;
  logic [CW-1:0]         cnt;
  logic                  blank_q;
  logic                  ovf_pend;
  logic [DW-1:0]         disp_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_n;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic                  wrap;
  logic [6:0]            pat_n;
  logic [NUM_DIGITS-1:0] an_n;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Blank mask: a digit is blank when it and all higher displayed digits are 0.
  always_comb begin
    logic allz;
    int unsigned k;
    mask_n = '0;
    allz   = 1'b1;
    k      = 0;
    for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
      k         = NUM_DIGITS - j;
      allz      = allz & (bcd_q[k*4 +: 4] == 4'd0);
      mask_n[k] = allz & blank_q;
    end
  end

  // Handshake and conversion FSM; LOAD commits digits, mask and ovf together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_out <= 1'b1;
      done      <= 1'b0;
      ovf       <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt       <= '0;
      blank_q   <= 1'b0;
      ovf_pend  <= 1'b0;
      disp_q    <= '0;
      mask_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            bin_q     <= num;
            blank_q   <= blank_lz;
            ovf_pend  <= (32'(num) >= LIMIT);
            bcd_q     <= '0;
            cnt       <= CW'(IN_WIDTH);
            ready_out <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt            <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= LOAD;
        end
        LOAD: begin
          disp_q    <= bcd_q[DW-1:0];
          mask_q    <= ovf_pend ? '0 : mask_n;
          ovf       <= ovf_pend;
          done      <= 1'b1;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next scan position and the segment pattern for the digit it selects.
  always_comb begin
    wrap  = (presc == PW'(SCAN_DIV - 1));
    idx_n = idx;
    if (wrap) idx_n = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    an_n        = '0;
    an_n[idx_n] = 1'b1;
    if (ovf)               pat_n = SEG_DASH;
    else if (mask_q[idx_n]) pat_n = 7'b0000000;
    else                   pat_n = enc(disp_q[idx_n*4 +: 4]);
  end

  // Free-running scan; enables and segments are registered from the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      an    <= AN_RST;
      seg   <= SEG_ZERO ^ SEG_POL;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      idx   <= idx_n;
      an    <= an_n ^ AN_POL;
      seg   <= pat_n ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed self-checking bench for seg_display_scan (4 digits, 14-bit input).
module tb_seg_display_scan;

  localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101;
  localparam logic [6:0] P7 = 7'b0000111, P9 = 7'b1100111;
  localparam logic [6:0] PB = 7'b0000000, PD = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [13:0] num = '0;
  logic        blank_lz = 1'b0;
  logic        ready_out, done, ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic        rst2 = 1'b1;
  logic        valid2 = 1'b0;
  logic [13:0] num2 = '0;
  logic        blank2 = 1'b0;
  logic        ready2, done2, ovf2;
  logic [6:0]  seg2;
  logic [3:0]  an2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seg_display_scan #(.NUM_DIGITS(4), .IN_WIDTH(14), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .num(num), .blank_lz(blank_lz),
    .ready_out(ready_out), .done(done), .ovf(ovf), .seg(seg), .an(an)
  );

  seg_display_scan #(.NUM_DIGITS(4), .IN_WIDTH(14), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst2), .valid_in(valid2), .num(num2), .blank_lz(blank2),
    .ready_out(ready2), .done(done2), .ovf(ovf2), .seg(seg2), .an(an2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for each digit enable in turn and checks its segments ({d3,d2,d1,d0}).
  task automatic check_digits(input string tag, input logic [27:0] exp);
    for (int unsigned k = 0; k < 4; k++) begin
      int unsigned w;
      w = 0;
      while (an !== 4'(1 << k) && w < 40) begin
        tick();
        w++;
      end
      chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(1 << k));
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp[k*7 +: 7]));
    end
  endtask

  // One full conversion with latency checks around the handshake.
  task automatic convert(input string tag, input logic [13:0] v, input logic b);
    int unsigned w;
    w = 0;
    while (!ready_out && w < 100) begin
      tick();
      w++;
    end
    chk({tag, "_rdy_wait"}, 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    num      = v;
    blank_lz = b;
    tick();
    valid_in = 1'b0;
    chk({tag, "_rdy_e0"}, 32'(ready_out), 32'd0);
    repeat (14) @(posedge clk);
    #1;
    chk({tag, "_rdy_e14"}, 32'({ready_out, done}), 32'd0);
    tick();
    chk({tag, "_done_e15"}, 32'({ready_out, done}), 32'b11);
    tick();
    chk({tag, "_done_e16"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned ndone;
    logic [27:0] pat321;

    // Test 1: reset values, asynchronous assertion, scan rotation.
    #23;
    rst  = 1'b0;
    rst2 = 1'b0;
    repeat (6) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t1_an_rst", 32'(an), 32'b0001);
    chk("t1_seg_rst", 32'(seg), 32'(P0));
    chk("t1_flags_rst", 32'({ready_out, ovf, done}), 32'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("t1_an_e3", 32'(an), 32'b0001);
    tick();
    chk("t1_an_e4", 32'(an), 32'b0010);
    repeat (4) tick();
    chk("t1_an_e8", 32'(an), 32'b0100);
    repeat (4) tick();
    chk("t1_an_e12", 32'(an), 32'b1000);
    chk("t1_seg_e12", 32'(seg), 32'(P0));
    repeat (4) tick();
    chk("t1_an_e16", 32'(an), 32'b0001);

    // Test 2: basic conversion.
    convert("t2_1234", 14'd1234, 1'b0);
    check_digits("t2_1234", {P1, P2, P3, P4});

    // Test 3: leading-zero blanking.
    convert("t3_7", 14'd7, 1'b1);
    check_digits("t3_7", {PB, PB, PB, P7});
    convert("t3_0", 14'd0, 1'b1);
    check_digits("t3_0", {PB, PB, PB, P0});
    convert("t3_1005", 14'd1005, 1'b1);
    check_digits("t3_1005", {P1, P0, P0, P5});

    // Test 4: overflow boundary.
    convert("t4_9999", 14'd9999, 1'b0);
    chk("t4_ovf_9999", 32'(ovf), 32'd0);
    check_digits("t4_9999", {P9, P9, P9, P9});
    convert("t4_10000", 14'd10000, 1'b1);
    chk("t4_ovf_10000", 32'(ovf), 32'd1);
    check_digits("t4_10000", {PD, PD, PD, PD});
    convert("t4_42", 14'd42, 1'b0);
    chk("t4_ovf_42", 32'(ovf), 32'd0);
    check_digits("t4_42", {P0, P0, P4, P2});

    // Test 5: valid held during a conversion is ignored until ready returns.
    pat321   = {P0, P3, P2, P1};
    valid_in = 1'b1;
    num      = 14'd321;
    blank_lz = 1'b0;
    tick();
    num   = 14'd55;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t5_done_cnt", 32'(ndone), 32'd1);
    chk("t5_done_e15", 32'(done), 32'd1);
    tick();
    chk("t5_acc55", 32'(ready_out), 32'd0);
    valid_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      for (int unsigned k = 0; k < 4; k++)
        if (an[k]) chk($sformatf("t5_show321_%0d", i), 32'(seg), 32'(pat321[k*7 +: 7]));
      if (done) ndone++;
      tick();
    end
    chk("t5_done_55", 32'(done), 32'd1);
    chk("t5_done_total", 32'(ndone), 32'd1);
    check_digits("t5_55", {P0, P0, P5, P5});

    // Test 6a: reset in the middle of a conversion discards it.
    valid_in = 1'b1;
    num      = 14'd9876;
    tick();
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rdy_rst", 32'(ready_out), 32'd1);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t6_no_done", 32'(ndone), 32'd0);
    check_digits("t6_zero", {P0, P0, P0, P0});

    // Test 6b: active-low outputs with SCAN_DIV=1.
    @(posedge clk);
    #3;
    rst2 = 1'b1;
    #1;
    chk("t6b_an_rst", 32'(an2), 32'b1110);
    chk("t6b_seg_rst", 32'(seg2), 32'b1000000);
    chk("t6b_flags_rst", 32'({ready2, ovf2, done2}), 32'b100);
    @(negedge clk);
    rst2 = 1'b0;
    tick();
    chk("t6b_an_e1", 32'(an2), 32'b1101);
    chk("t6b_seg_e1", 32'(seg2), 32'b1000000);
    tick();
    chk("t6b_an_e2", 32'(an2), 32'b1011);
    tick();
    chk("t6b_an_e3", 32'(an2), 32'b0111);
    tick();
    chk("t6b_an_e4", 32'(an2), 32'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
